mdu_sequencer: RTL and testbench

//   Parametrised multiply/divide unit for the EX stage, next to the ALU controller. Decodes MULT/MULTU/DIV/DIVU,

---
 rtl/mdu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit for the EX stage: decodes MULT/MULTU/DIV/DIVU, MFHI/MFLO and
// MTHI/MTLO, runs a shift-add multiply or restoring divide into HI/LO, and stalls EX
// only when an MDU instruction meets a busy unit.
// Optional feature macro: MDU_FAST_MULT_EN (single-cycle '*' multiply; divide unchanged).
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_alu_op,
  input  logic [5:0]       i_funct,
  input  logic             i_ex_valid,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic             o_mdu_stall,
  output logic             o_mdu_busy,
  output logic             o_mdu_rd_en,
  output logic [WIDTH-1:0] o_mdu_result,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef MDU_FAST_MULT_EN
  localparam logic [CntW-1:0] MulCnt = '0;
`else
  localparam logic [CntW-1:0] MulCnt = CntW'(WIDTH - 1);
`endif
  localparam logic [CntW-1:0] DivCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [WIDTH-1:0]   r_acc_hi;   // partial product high half / partial remainder
  logic [WIDTH-1:0]   r_acc_lo;   // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0]   r_b;        // multiplicand / divisor magnitude
  logic               r_neg_p;    // negate product or quotient on the final write
  logic               r_neg_r;    // negate remainder on the final write

  logic w_rtype, w_mfhi, w_mthi, w_mflo, w_mtlo, w_mult, w_multu, w_div, w_divu;
  logic w_mul_op, w_div_op, w_sign_op, w_is_mdu, w_idle, w_accept;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum, w_div_shift;
  logic [WIDTH-1:0]   w_mul_hi, w_mul_lo, w_div_sub, w_div_rem, w_div_quo;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
  logic               w_div_ge;

  // Decode the EX instruction and qualify it; nothing is accepted while reset is held.
  always_comb begin
    w_rtype   = (i_alu_op == 3'b010);
    w_mfhi    = w_rtype & (i_funct == 6'b010000);
    w_mthi    = w_rtype & (i_funct == 6'b010001);
    w_mflo    = w_rtype & (i_funct == 6'b010010);
    w_mtlo    = w_rtype & (i_funct == 6'b010011);
    w_mult    = (w_rtype & (i_funct == 6'b011000)) | (i_alu_op == 3'b111);
    w_multu   = w_rtype & (i_funct == 6'b011001);
    w_div     = w_rtype & (i_funct == 6'b011010);
    w_divu    = w_rtype & (i_funct == 6'b011011);
    w_mul_op  = w_mult | w_multu;
    w_div_op  = w_div | w_divu;
    w_sign_op = w_mult | w_div;
    w_is_mdu  = i_ex_valid & ~i_flush & ~i_rst &
                (w_mfhi | w_mthi | w_mflo | w_mtlo | w_mul_op | w_div_op);
    w_idle    = (r_state == StIdle);
    w_accept  = w_is_mdu & w_idle & (w_mul_op | w_div_op);
    w_abs_a   = (w_sign_op & i_src_a[WIDTH-1]) ? -i_src_a : i_src_a;
    w_abs_b   = (w_sign_op & i_src_b[WIDTH-1]) ? -i_src_b : i_src_b;
  end

  // One iteration step of each datapath, plus the sign fix-up for the final write.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);
    w_mul_hi    = w_mul_sum[WIDTH:1];
    w_mul_lo    = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    // When the subtract succeeds the difference is below the divisor, so W bits suffice.
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;
    w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
    w_div_quo   = {r_acc_lo[WIDTH-2:0], w_div_ge};
`ifdef MDU_FAST_MULT_EN
    w_prod      = {{WIDTH{1'b0}}, r_acc_lo} * {{WIDTH{1'b0}}, r_b};
`else
    w_prod      = {w_mul_hi, w_mul_lo};
`endif
    w_prod_fix  = r_neg_p ? -w_prod : w_prod;
    // Divide by zero: all-ones quotient; remainder fix-up restores the raw dividend.
    w_quo_fix   = (r_b == '0) ? '1 : (r_neg_p ? -w_div_quo : w_div_quo);
    w_rem_fix   = r_neg_r ? -w_div_rem : w_div_rem;
  end

  // Sequencer FSM with HI/LO, datapath and busy registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_b      <= '0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state  <= w_mul_op ? StMul : StDiv;
            r_busy   <= 1'b1;
            r_cnt    <= w_mul_op ? MulCnt : DivCnt;
            r_acc_hi <= '0;
            r_acc_lo <= w_abs_a;
            r_b      <= w_abs_b;
            r_neg_p  <= w_sign_op & (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
            r_neg_r  <= w_sign_op & i_src_a[WIDTH-1];
          end else if (w_is_mdu & w_mthi) begin
            r_hi <= i_src_a;
          end else if (w_is_mdu & w_mtlo) begin
            r_lo <= i_src_a;
          end
        end
        StMul: begin
          r_acc_hi <= w_mul_hi;
          r_acc_lo <= w_mul_lo;
          if (r_cnt == '0) begin
            r_hi    <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod_fix[WIDTH-1:0];
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StDiv: begin
          r_acc_hi <= w_div_rem;
          r_acc_lo <= w_div_quo;
          if (r_cnt == '0) begin
            r_hi    <= w_rem_fix;
            r_lo    <= w_quo_fix;
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline-facing outputs: stall and HI/LO reads are combinational on the EX op.
  always_comb begin
    o_mdu_stall  = w_is_mdu & ~w_idle;
    o_mdu_rd_en  = w_is_mdu & w_idle & (w_mfhi | w_mflo);
    o_mdu_result = '0;
    if (o_mdu_rd_en) o_mdu_result = w_mfhi ? r_hi : r_lo;
    o_mdu_busy   = r_busy;
    o_hi         = r_hi;
    o_lo         = r_lo;
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus randomized
// MULT/MULTU/DIV/DIVU traffic checked against a plain-arithmetic HI/LO model.
module tb_mdu_sequencer;

`ifdef MDU_FAST_MULT_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 32;
`endif
  localparam int DivLat = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic        ex_valid, flush;
  logic [31:0] src_a, src_b;
  logic        mdu_stall, mdu_busy, mdu_rd_en;
  logic [31:0] mdu_result, hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  mdu_sequencer #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_alu_op(alu_op), .i_funct(funct),
    .i_ex_valid(ex_valid), .i_flush(flush), .i_src_a(src_a), .i_src_b(src_b),
    .o_mdu_stall(mdu_stall), .o_mdu_busy(mdu_busy), .o_mdu_rd_en(mdu_rd_en),
    .o_mdu_result(mdu_result), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: HI/LO from 64-bit arithmetic on the architectural operands.
  function automatic void model(input logic [2:0] alu, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo,
                                output int lat);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (alu == 3'b111 || fn == F_MULT) begin
      p = sa * sb; ehi = p[63:32]; elo = p[31:0]; lat = MulLat;
    end else if (fn == F_MULTU) begin
      up = {32'b0, a} * {32'b0, b}; ehi = up[63:32]; elo = up[31:0]; lat = MulLat;
    end else begin
      lat = DivLat;
      if (b == 32'b0) begin
        ehi = a; elo = 32'hFFFF_FFFF;
      end else if (fn == F_DIV) begin
        q = sa / sb; r = sa % sb; elo = q[31:0]; ehi = r[31:0];
      end else begin
        elo = a / b; ehi = a % b;
      end
    end
  endfunction

  task automatic drive(input logic [2:0] alu, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1; flush = 1'b0; alu_op = alu; funct = fn; src_a = a; src_b = b;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; flush = 1'b0; alu_op = 3'b000; funct = 6'b0;
  endtask

  // Holds the current EX op and counts stalled cycles, bounded.
  task automatic wait_unstall(output int n);
    n = 0;
    #1;
    while (mdu_stall === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one MUL/DIV, read LO back via a stalled MFLO, then HI via MFHI in IDLE.
  task automatic test_md_op(input logic [2:0] alu, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] ehi, elo;
    int lat, n;
    model(alu, fn, a, b, ehi, elo, lat);
    @(negedge clk); drive(alu, fn, a, b); #1;
    checks++; if (mdu_stall !== 1'b0) begin errors++; $display("FAIL %s accept_stall: got %b want 0", name, mdu_stall); end
    @(negedge clk); drive(3'b010, F_MFLO, $urandom, $urandom); #1;
    checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", name, mdu_busy); end
    wait_unstall(n);
    checks++; if (n != lat) begin errors++; $display("FAIL %s stall_cycles: got %0d want %0d", name, n, lat); end
    checks++; if (mdu_rd_en !== 1'b1 || mdu_result !== elo) begin errors++; $display("FAIL %s mflo: got rd_en=%b %h want 1 %h", name, mdu_rd_en, mdu_result, elo); end
    checks++; if (hi !== ehi || lo !== elo) begin errors++; $display("FAIL %s hilo: got %h_%h want %h_%h (a=%h b=%h)", name, hi, lo, ehi, elo, a, b); end
    @(negedge clk); drive(3'b010, F_MFHI, $urandom, $urandom); #1;
    checks++; if (mdu_stall !== 1'b0 || mdu_rd_en !== 1'b1 || mdu_result !== ehi) begin errors++; $display("FAIL %s mfhi: got stall=%b rd_en=%b %h want 0 1 %h", name, mdu_stall, mdu_rd_en, mdu_result, ehi); end
    m_hi = ehi; m_lo = elo;
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_idle(); src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    drive(3'b111, F_MULT, 32'd5, 32'd6); #1;
    checks++; if (mdu_stall !== 1'b0 || mdu_busy !== 1'b0 || mdu_rd_en !== 1'b0) begin errors++; $display("FAIL reset ctrl: got stall=%b busy=%b rd_en=%b want 000", mdu_stall, mdu_busy, mdu_rd_en); end
    checks++; if (mdu_result !== 32'h0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset data: got res=%h hi=%h lo=%h want 0", mdu_result, hi, lo); end
    @(negedge clk); drive_idle(); rst = 1'b0; #1;
    checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL reset no_accept: got busy=%b want 0", mdu_busy); end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_directed();
    test_md_op(3'b010, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_max const: got %h_%h want fffffffe_00000001", hi, lo); end
    test_md_op(3'b111, 6'($urandom), -32'sd7, 32'sd3, "mult_alu7");
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_alu7 const: got %h_%h want ffffffff_ffffffeb", hi, lo); end
    test_md_op(3'b010, F_DIV, -32'sd7, 32'sd2, "div_neg");
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg const: got %h_%h want ffffffff_fffffffd", hi, lo); end
    test_md_op(3'b010, F_DIVU, 32'd7, 32'd0, "divu_zero");
    checks++; if (hi !== 32'h7 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero const: got %h_%h want 00000007_ffffffff", hi, lo); end
    test_md_op(3'b010, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    checks++; if (hi !== 32'h0 || lo !== 32'h8000_0000) begin errors++; $display("FAIL div_min_m1 const: got %h_%h want 00000000_80000000", hi, lo); end
    test_md_op(3'b010, F_DIV, -32'sd9, 32'd0, "div_zero_signed");
  endtask

  task automatic test_random();
    logic [5:0] fns [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    for (int i = 0; i < 24; i++) begin
      int k = $urandom_range(0, 4);
      if (k == 4) test_md_op(3'b111, 6'($urandom), pick(), pick(), "rand_mult7");
      else        test_md_op(3'b010, fns[k], pick(), pick(), "rand");
    end
  endtask

  task automatic test_mt_while_busy();
    logic [31:0] ehi, elo, a, b, v;
    int lat, n;
    a = $urandom; b = 32'($urandom_range(1, 99));
    model(3'b010, F_DIVU, a, b, ehi, elo, lat);
    @(negedge clk); drive(3'b010, F_DIVU, a, b);
    @(negedge clk); drive(3'b010, F_MTHI, 32'h1234, $urandom);
    wait_unstall(n);
    checks++; if (n != DivLat) begin errors++; $display("FAIL mthi_busy stall_cycles: got %0d want %0d", n, DivLat); end
    checks++; if (hi !== ehi || lo !== elo) begin errors++; $display("FAIL mthi_busy div_result: got %h_%h want %h_%h", hi, lo, ehi, elo); end
    @(negedge clk); drive(3'b010, F_MFHI, $urandom, $urandom); #1;
    checks++; if (mdu_rd_en !== 1'b1 || mdu_result !== 32'h1234 || lo !== elo) begin errors++; $display("FAIL mthi_busy after: got rd_en=%b hi=%h lo=%h want 1 00001234 %h", mdu_rd_en, mdu_result, lo, elo); end
    v = $urandom;
    @(negedge clk); drive(3'b010, F_MTLO, v, $urandom);
    @(negedge clk); drive_idle(); #1;
    checks++; if (lo !== v || hi !== 32'h1234) begin errors++; $display("FAIL mtlo_idle: got %h_%h want 00001234_%h", hi, lo, v); end
    m_hi = 32'h1234; m_lo = v;
  endtask

  task automatic test_flush();
    @(negedge clk); drive(3'b111, F_MULT, $urandom, $urandom); flush = 1'b1; #1;
    checks++; if (mdu_stall !== 1'b0) begin errors++; $display("FAIL flush_mult stall: got %b want 0", mdu_stall); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL flush_mult busy: got %b want 0", mdu_busy); end
    @(negedge clk); drive(3'b010, F_MTHI, ~m_hi, $urandom); flush = 1'b1;
    @(negedge clk); drive(3'b010, F_MFLO, $urandom, $urandom); flush = 1'b1; #1;
    checks++; if (mdu_rd_en !== 1'b0 || mdu_result !== 32'h0) begin errors++; $display("FAIL flush_mflo: got rd_en=%b %h want 0 0", mdu_rd_en, mdu_result); end
    checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL flush hilo: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    drive_idle();
  endtask

  task automatic test_non_mdu();
    logic [31:0] ehi, elo;
    int lat;
    @(negedge clk); drive(3'b010, F_ADD, $urandom, $urandom); #1;
    checks++; if (mdu_stall !== 1'b0 || mdu_rd_en !== 1'b0 || mdu_result !== 32'h0) begin errors++; $display("FAIL non_mdu idle: got stall=%b rd_en=%b %h want 0 0 0", mdu_stall, mdu_rd_en, mdu_result); end
    @(negedge clk); drive(3'b000, F_MFHI, $urandom, $urandom); #1;
    checks++; if (mdu_rd_en !== 1'b0) begin errors++; $display("FAIL non_mdu aluop: got rd_en=%b want 0", mdu_rd_en); end
    model(3'b010, F_MULTU, 32'd1000, 32'd77, ehi, elo, lat);
    @(negedge clk); drive(3'b010, F_MULTU, 32'd1000, 32'd77);
    @(negedge clk); drive(3'b010, F_ADD, $urandom, $urandom); #1;
    checks++; if (mdu_stall !== 1'b0 || mdu_busy !== 1'b1) begin errors++; $display("FAIL non_mdu busy: got stall=%b busy=%b want 0 1", mdu_stall, mdu_busy); end
    drive_idle();
    repeat (lat + 1) @(negedge clk);
    #1;
    checks++; if (mdu_busy !== 1'b0 || hi !== ehi || lo !== elo) begin errors++; $display("FAIL non_mdu result: got busy=%b %h_%h want 0 %h_%h", mdu_busy, hi, lo, ehi, elo); end
    m_hi = ehi; m_lo = elo;
  endtask

  task automatic test_back_to_back();
    logic [31:0] h1, l1, h2, l2, a1, b1, a2, b2;
    int lat1, lat2, n;
    a1 = pick(); b1 = pick(); a2 = pick(); b2 = pick();
    model(3'b010, F_MULT, a1, b1, h1, l1, lat1);
    model(3'b010, F_DIV, a2, b2, h2, l2, lat2);
    @(negedge clk); drive(3'b010, F_MULT, a1, b1);
    @(negedge clk); drive(3'b010, F_DIV, a2, b2);
    wait_unstall(n);
    checks++; if (n != lat1) begin errors++; $display("FAIL b2b div_stall: got %0d want %0d", n, lat1); end
    checks++; if (mdu_busy !== 1'b0 || hi !== h1 || lo !== l1) begin errors++; $display("FAIL b2b mul_done: got busy=%b %h_%h want 0 %h_%h", mdu_busy, hi, lo, h1, l1); end
    @(negedge clk); drive(3'b010, F_MFLO, $urandom, $urandom); #1;
    checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL b2b div_accept: got busy=%b want 1", mdu_busy); end
    wait_unstall(n);
    checks++; if (n != lat2 || mdu_result !== l2 || hi !== h2) begin errors++; $display("FAIL b2b div_result: got n=%0d lo=%h hi=%h want %0d %h %h", n, mdu_result, hi, lat2, l2, h2); end
    drive_idle();
    m_hi = h2; m_lo = l2;
  endtask

  task automatic test_rst_mid();
    @(negedge clk); drive(3'b010, F_MTHI, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk); drive(3'b010, F_MTLO, 32'hCAFE_F00D, 32'h0);
    @(negedge clk); drive(3'b010, F_DIV, 32'd1000, 32'd3);
    @(negedge clk); drive(3'b010, F_MFHI, 32'h0, 32'h0);
    repeat (21) @(posedge clk);
    #2;
    checks++; if (mdu_busy !== 1'b1 || hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_mid before: got busy=%b hi=%h want 1 deadbeef", mdu_busy, hi); end
    rst = 1'b1; #1;
    checks++; if (mdu_busy !== 1'b0 || mdu_stall !== 1'b0 || mdu_rd_en !== 1'b0 || mdu_result !== 32'h0) begin errors++; $display("FAIL rst_mid ctrl: got busy=%b stall=%b rd_en=%b res=%h want 0", mdu_busy, mdu_stall, mdu_rd_en, mdu_result); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rst_mid hilo: got %h_%h want 0_0", hi, lo); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (mdu_stall !== 1'b0 || mdu_rd_en !== 1'b1 || mdu_result !== 32'h0) begin errors++; $display("FAIL rst_mid mfhi: got stall=%b rd_en=%b %h want 0 1 0", mdu_stall, mdu_rd_en, mdu_result); end
    drive_idle();
    m_hi = '0; m_lo = '0;
    test_md_op(3'b010, F_DIVU, 32'd100, 32'd7, "after_rst");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_mt_while_busy();
    test_flush();
    test_non_mdu();
    test_back_to_back();
    test_random();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
